// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and store lane-mask helper for the data-memory responder.
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_B ? 4'b0001 << lane : size == SZ_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'hF;
  endfunction
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: store byte-mask/data replication and load lane extract with zero-extension.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  assign mask_o  = lane_mask(size_i, lane_i);
  assign wdata_o = size_i == SZ_B ? {4{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
  assign rdata_o = size_i == SZ_B ? {24'b0, word_i[{lane_i, 3'b000} +: 8]}
                 : size_i == SZ_H ? {16'b0, word_i[{lane_i[1], 4'b0000} +: 16]} : word_i;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding valid/ready data memory with fixed access latency.
// Define DMEM_ERR_EN to flag out-of-range and misaligned accesses on resp_err_o instead of wrapping.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  localparam int AW = $clog2(DEPTH);
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wen_q, req_ready_q, resp_valid_q, resp_err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, resp_rdata_q;
  logic [31:0] mem_q [DEPTH];
  logic        a_wen, commit, err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_off, word, st_data, ld_data;
  logic [AW-1:0] idx;
  logic [3:0]  mask;
  // With single-cycle latency the access commits on the accept edge, so it must use the live request.
  assign a_wen   = state_q == S_IDLE ? req_wen_i   : wen_q;
  assign a_size  = state_q == S_IDLE ? req_size_i  : size_q;
  assign a_addr  = state_q == S_IDLE ? req_addr_i  : addr_q;
  assign a_wdata = state_q == S_IDLE ? req_wdata_i : wdata_q;
  assign a_off   = a_addr - BASE_ADDR;
  assign idx     = AW'(a_off >> 2);
  assign word    = mem_q[idx];
  assign commit  = (state_q == S_IDLE && req_valid_i && LATENCY == 1) || (state_q == S_WAIT && cnt_q == 4'd1);
`ifdef DMEM_ERR_EN
  assign err = (a_off >= 32'(DEPTH * 4)) || (a_size == SZ_H && a_addr[0]) || (a_size[1] && a_addr[1:0] != 2'b00);
`else
  assign err = 1'b0;
`endif
  dmem_lane u_lane (
    .size_i (a_size),
    .lane_i (a_addr[1:0]),
    .wdata_i(a_wdata),
    .word_i (word),
    .mask_o (mask),
    .wdata_o(st_data),
    .rdata_o(ld_data)
  );
  always_ff @(posedge clk)
    if (!rst && commit && a_wen && !err)
      for (int b = 0; b < 4; b++)
        if (mask[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          wen_q       <= req_wen_i;
          size_q      <= req_size_i;
          addr_q      <= req_addr_i;
          wdata_q     <= req_wdata_i;
          cnt_q       <= 4'(LATENCY - 1);
          req_ready_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: cnt_q <= cnt_q - 4'd1;
        S_RESP: if (resp_ready_i) begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (commit) begin
        state_q      <= S_RESP;
        resp_valid_q <= 1'b1;
        resp_rdata_q <= (a_wen || err) ? 32'd0 : ld_data;
        resp_err_q   <= err;
      end
    end
  end
  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven transactions with a response scoreboard, plus hold and mid-access reset sequences.
module tb_dmem_responder;
  import dmem_pkg::*;
`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int checks = 0, failures = 0;
  logic [32:0] sb_q [$];
  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t vecs [$];
  always #5 clk = ~clk;
  dmem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic txn(input logic wen, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic err, input int hold);
    int n;
    logic [31:0] r0;
    logic [32:0] e;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
    sb_q.push_back({err, rdata});
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 32'd2);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    r0 = resp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, r0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    e = sb_q.pop_front();
    chk("rdata", resp_rdata, e[31:0]);
    chk("err", 32'(resp_err), 32'(e[32]));
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask
  initial begin
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, SZ_B, 32'h8000_0013, 32'hFFFF_FF5A, 32'h0, 1'b0});
    vecs.push_back('{1'b0, SZ_B, 32'h8000_0013, 32'h0, 32'h0000_005A, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0010, 32'h0, 32'h5AAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, SZ_H, 32'h8000_0012, 32'hABCD_1234, 32'h0, 1'b0});
    vecs.push_back('{1'b0, SZ_H, 32'h8000_0012, 32'h0, 32'h0000_1234, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0010, 32'h0, 32'h1234_BEEF, 1'b0});
    vecs.push_back('{1'b0, SZ_B, 32'h8000_0011, 32'h0, 32'h0000_00BE, 1'b0});
    vecs.push_back('{1'b0, SZ_H, 32'h8000_0010, 32'h0, 32'h0000_BEEF, 1'b0});
    vecs.push_back('{1'b0, SZ_B, 32'h8000_0012, 32'h0, 32'h0000_0034, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 32'h8000_0004, 32'h0BAD_C0DE, 32'h0, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0004, 32'h0, 32'h0BAD_C0DE, 1'b0});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0000, 32'h1122_3344, 32'h0, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0002, 32'h0, ERR ? 32'h0 : 32'h1122_3344, ERR});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_1000, 32'hCAFE_F00D, 32'h0, ERR});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0000, 32'h0, ERR ? 32'h1122_3344 : 32'hCAFE_F00D, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++)
      txn(vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 0);
    txn(1'b0, SZ_W, 32'h8000_0010, 32'h0, 32'h1234_BEEF, 1'b0, 5);
    txn(1'b1, SZ_W, 32'h8000_0020, 32'h5566_7788, 32'h0, 1'b0, 0);
    req_valid = 1'b1; req_wen = 1'b1; req_size = SZ_W; req_addr = 32'h8000_0020; req_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_err", 32'(resp_err), 32'd0);
    txn(1'b0, SZ_W, 32'h8000_0020, 32'h0, 32'h5566_7788, 1'b0, 0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the NPC core. It is the memory side of the load/store path that feeds `rdata` into the ALU result mux for lw/lbu. It accepts one request at a time over a valid/ready handshake and performs the access on an internal word array after a fixed latency. Read data comes back already lane-extracted and zero-extended, so the core uses `rdata` directly as the load result.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two)
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request-accept edge to `resp_valid` high (legal 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_wen  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word; 3 = reserved, treated as word
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  response present
resp_ready  input  1  core accepts response
resp_rdata  output  32  load data, zero-extended; 0 for stores
resp_err  output  1  error flag (only meaningful with DMEM_ERR_EN; else tied 0)

Behaviour:
- Reset (sync, `rst`=1 at edge): state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0. Array contents are not reset.
- Reset mid-operation aborts the access. A pending store not yet committed is dropped.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: `req_ready`=1. On `req_valid`&`req_ready`: latch wen, size, addr and wdata; counter<=LATENCY-1. Go to RESP if LATENCY==1, else go to WAIT.
  - WAIT: `req_ready`=0. Counter decrements each cycle. Going from counter==1 to 0 moves the FSM to RESP.
  - RESP: the array access commits on the edge entering RESP. `resp_valid`=1 and holds with stable rdata/err until `resp_ready`. On the handshake edge, go to IDLE with `resp_valid`=0.
- No back-to-back accept in the handshake cycle. `req_ready` rises the cycle after the response handshake, so at most one request is outstanding.
- Address decode: offset = addr − BASE_ADDR; word index = offset[log2(DEPTH)+1:2]; lane = addr[1:0].
  - Without DMEM_ERR_EN, out-of-range offsets wrap modulo DEPTH words.
- Alignment: a half uses lane[1] only (lane[0] ignored); a word uses lane 0 (lane[1:0] ignored).
- Load result:
  - byte: rdata = {24'b0, word[8*lane +: 8]}.
  - half: rdata = {16'b0, word[16*lane[1] +: 16]}.
  - word: rdata = word.
- Store: build a byte mask and shifted data; only masked lanes of the array word change.
  - byte: mask = 1 << lane, data = wdata[7:0] replicated ×4.
  - half: mask = 2'b11 << 2*lane[1], data = wdata[15:0] replicated ×2.
  - word: mask = 4'hF, data = wdata.
- `req_*` inputs are ignored outside IDLE. The core may change them freely once they have been accepted.

Optional Feature:
DMEM_ERR_EN
- Defined: `resp_err`=1 for either of two cases:
  - offset ≥ DEPTH*4;
  - misalignment, i.e. half with addr[0]=1, or word/reserved size with addr[1:0]≠0.
- Erroring requests still take LATENCY cycles. They do not modify the array and return rdata=0.
- Not defined: `resp_err` is constant 0, addresses wrap, and misaligned low bits are ignored as stated above.

Decomposition:
- Shared package `dmem_pkg` holds:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2;
  - FSM state encoding;
  - the lane-mask function.
- One sub-module, `dmem_lane`: combinational store mask/data generator and load extract/zero-extend, with inputs size, lane, wdata and array word. The FSM, counter and array stay in `dmem_responder`.

Test Plan:
- Store word 32'hDEAD_BEEF at 0x8000_0010, then load word there (LATENCY=2) -> `resp_valid` high exactly 2 cycles after each accept; load rdata=32'hDEAD_BEEF; store rdata=0.
- Store byte 8'h5A at 0x8000_0013, then lbu at 0x8000_0013 -> rdata=32'h0000_005A; word load at 0x8000_0010 returns 32'h5AAD_BEEF.
- Store half 16'h1234 at 0x8000_0012, then load half -> rdata=32'h0000_1234; word load returns 32'h1234_BEEF.
- Hold `resp_ready`=0 for 5 cycles in RESP -> `resp_valid`, rdata stable; `req_ready`=0 throughout; `req_ready`=1 the cycle after handshake.
- Assert `rst` while in WAIT for a store of 32'hFFFF_FFFF to 0x8000_0020 -> next cycle outputs at reset values; subsequent word load at 0x8000_0020 returns the prior value.
- With DMEM_ERR_EN: word load at 0x8000_0002, and store to BASE_ADDR+DEPTH*4 -> both give `resp_err`=1, rdata=0, no array change. Without the macro, the first returns the word at 0x8000_0000.
